// File: rtl/led4x4_scan_ctrl.sv
// led4x4_scan_ctrl: bus-mapped 4x4 LED scan controller with per-LED 4-bit PWM,
// row sequencing with a blanking slot before every row, and frame-aligned brightness shadowing.
module led4x4_scan_ctrl #(
  parameter logic [15:0] RESET_PRESCALE = 16'd999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out,
  output logic [3:0]  aled,
  output logic [3:0]  kled_tri
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRE    = 3'd1;
  localparam logic [2:0] OFF_LO     = 3'd2;
  localparam logic [2:0] OFF_HI     = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  logic        r_enable, r_blank;
  logic [15:0] r_prescale, r_pc;
  logic [31:0] r_bright_lo, r_bright_hi;
  logic [63:0] r_shadow;
  state_t      r_state;
  logic [1:0]  r_row;
  logic [3:0]  r_phase;
  logic [7:0]  r_frame_cnt;
  logic [3:0]  r_aled, r_kled;

  logic [2:0]  w_off;
  logic        w_wr_ctrl, w_stop, w_tick, w_latch, w_busy;
  state_t      w_state_nxt;
  logic [1:0]  w_row_nxt;
  logic [3:0]  w_phase_nxt, w_aled_nxt, w_kled_nxt;
  logic [7:0]  w_frame_nxt;
  logic [31:0] w_rd;
  logic        w_unused_bits;

  assign w_off     = address_in[4:2];
  assign w_wr_ctrl = sel_in && (w_off == OFF_CTRL) && write_mask_in[0];
  // Clearing enable must silence the matrix on the very next edge, not one cycle later.
  assign w_stop    = w_wr_ctrl && !write_value_in[0];
  assign w_tick    = (r_pc >= r_prescale);
  assign w_busy    = (r_state != ST_IDLE);
  assign ready_out = sel_in;
  assign aled      = r_aled;
  assign kled_tri  = r_kled;
  assign w_unused_bits = ^{read_in, address_in[31:5], address_in[1:0]};

  // Bus-visible configuration registers with independent byte lanes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_enable    <= 1'b0;
      r_blank     <= 1'b0;
      r_prescale  <= RESET_PRESCALE;
      r_bright_lo <= 32'd0;
      r_bright_hi <= 32'd0;
    end else begin
      if (w_wr_ctrl) begin
        r_enable <= write_value_in[0];
        r_blank  <= write_value_in[1];
      end
      for (int b = 0; b < 2; b++) begin
        if (sel_in && (w_off == OFF_PRE) && write_mask_in[b])
          r_prescale[b*8 +: 8] <= write_value_in[b*8 +: 8];
      end
      for (int b = 0; b < 4; b++) begin
        if (sel_in && (w_off == OFF_LO) && write_mask_in[b])
          r_bright_lo[b*8 +: 8] <= write_value_in[b*8 +: 8];
        if (sel_in && (w_off == OFF_HI) && write_mask_in[b])
          r_bright_hi[b*8 +: 8] <= write_value_in[b*8 +: 8];
      end
    end
  end

  // PWM tick prescaler, parked at zero while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            r_pc <= 16'd0;
    else if (r_state == ST_IDLE || w_stop) r_pc <= 16'd0;
    else if (w_tick)                       r_pc <= 16'd0;
    else                                   r_pc <= r_pc + 16'd1;
  end

  // FSM state register together with row, phase and frame counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_row       <= 2'd0;
      r_phase     <= 4'd0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_phase     <= w_phase_nxt;
      r_frame_cnt <= w_frame_nxt;
    end
  end

  // Next-state logic for the blank/active row sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_phase_nxt = r_phase;
    w_frame_nxt = r_frame_cnt;
    w_latch     = 1'b0;
    if (w_stop) begin
      w_state_nxt = ST_IDLE;
      w_row_nxt   = 2'd0;
      w_phase_nxt = 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_row_nxt   = 2'd0;
          w_phase_nxt = 4'd0;
          if (r_enable) begin
            w_state_nxt = ST_BLANK;
            w_latch     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BLANK: begin
          if (w_tick) begin
            w_state_nxt = ST_ACTIVE;
            w_phase_nxt = 4'd0;
          end else begin
            w_state_nxt = ST_BLANK;
          end
        end
        ST_ACTIVE: begin
          if (w_tick && r_phase == 4'd15) begin
            w_state_nxt = ST_BLANK;
            w_phase_nxt = 4'd0;
            w_row_nxt   = r_row + 2'd1;
            // Shadow reload only at the frame boundary keeps a frame tear-free.
            if (r_row == 2'd3) begin
              w_frame_nxt = r_frame_cnt + 8'd1;
              w_latch     = 1'b1;
            end else begin
              w_frame_nxt = r_frame_cnt;
            end
          end else if (w_tick) begin
            w_phase_nxt = r_phase + 4'd1;
          end else begin
            w_phase_nxt = r_phase;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_row_nxt   = 2'd0;
          w_phase_nxt = 4'd0;
        end
      endcase
    end
  end

  // Brightness shadow copy used for the whole frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_shadow <= 64'd0;
    else if (w_latch) r_shadow <= {r_bright_hi, r_bright_lo};
    else              r_shadow <= r_shadow;
  end

  // Output decode: anode one-hot plus PWM compare per column
  always_comb begin
    w_aled_nxt = 4'b0000;
    w_kled_nxt = 4'hF;
    if (!w_stop && r_state == ST_ACTIVE) begin
      w_aled_nxt = 4'b0001 << r_row;
      for (int c = 0; c < 4; c++) begin
        w_kled_nxt[c] = r_blank | !(r_shadow[{r_row, 2'(c), 2'b00} +: 4] > r_phase);
      end
    end else begin
      w_aled_nxt = 4'b0000;
      w_kled_nxt = 4'hF;
    end
  end

  // Registered pad drive
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_aled <= 4'b0000;
      r_kled <= 4'hF;
    end else begin
      r_aled <= w_aled_nxt;
      r_kled <= w_kled_nxt;
    end
  end

  // Combinational read mux
  always_comb begin
    w_rd = 32'd0;
    case (w_off)
      OFF_CTRL:   w_rd = {30'd0, r_blank, r_enable};
      OFF_PRE:    w_rd = {16'd0, r_prescale};
      OFF_LO:     w_rd = r_bright_lo;
      OFF_HI:     w_rd = r_bright_hi;
      OFF_STATUS: w_rd = {21'd0, w_busy, r_row, r_frame_cnt};
      default:    w_rd = 32'd0;
    endcase
  end

  assign read_value_out = (sel_in && reset) ? w_rd : 32'd0;

endmodule

// File: tb/tb_led4x4_scan_ctrl.sv
// Scoreboard bench for led4x4_scan_ctrl: expected pad/read values are queued from an
// independent frame-position model and popped against captured DUT outputs.
`timescale 1ns/1ps
module tb_led4x4_scan_ctrl;

  localparam logic [31:0] AD_CTRL = 32'h0004_0000;
  localparam logic [31:0] AD_PRE  = 32'h0004_0004;
  localparam logic [31:0] AD_LO   = 32'h0004_0008;
  localparam logic [31:0] AD_HI   = 32'h0004_000C;
  localparam logic [31:0] AD_STAT = 32'h0004_0010;
  localparam logic [31:0] AD_R5   = 32'h0004_0014;
  localparam logic [31:0] AD_R7   = 32'h0004_001C;
  localparam logic [7:0]  OFF     = 8'h0F;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;
  logic [3:0]  aled;
  logic [3:0]  kled_tri;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  logic [31:0] exp_rd_q[$];

  always #5 clk = ~clk;

  led4x4_scan_ctrl #(.RESET_PRESCALE(16'd999)) dut (
    .clk(clk), .reset(reset), .address_in(address_in), .sel_in(sel_in),
    .read_in(read_in), .read_value_out(read_value_out), .write_mask_in(write_mask_in),
    .write_value_in(write_value_in), .ready_out(ready_out), .aled(aled), .kled_tri(kled_tri)
  );

  // Pads for frame position m (clock edges since the scan left IDLE, minus one).
  function automatic logic [7:0] model_out(input int m, input int p, input logic [63:0] sh,
                                           input logic blank);
    int t, pos, row, r, phase;
    logic [3:0] a, k, lvl;
    if (m < 0) return OFF;
    t = p + 1;
    pos = m % (68 * t);
    row = pos / (17 * t);
    r = pos % (17 * t);
    if (r < t) return OFF;
    phase = (r - t) / t;
    a = 4'b0000;
    a[row] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      lvl = sh[(row * 4 + c) * 4 +: 4];
      k[c] = blank || !(int'(lvl) > phase);
    end
    return {a, k};
  endfunction

  function automatic logic [31:0] model_status(input int m, input int p);
    int t, pos;
    t = p + 1;
    pos = m % (68 * t);
    return {21'd0, 1'b1, 2'(pos / (17 * t)), 8'(m / (68 * t))};
  endfunction

  task automatic bus_write(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    address_in = addr; sel_in = 1'b1; write_mask_in = mask; write_value_in = data;
    @(posedge clk); #1;
    sel_in = 1'b0; write_mask_in = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    address_in = addr; sel_in = 1'b1; read_in = 1'b1;
    #1;
    data = read_value_out;
    sel_in = 1'b0; read_in = 1'b0;
  endtask

  task automatic capture(input int n, input int wr_at, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data);
    for (int i = 0; i < n; i++) begin
      if (i == wr_at) begin
        address_in = addr; sel_in = 1'b1; write_mask_in = mask; write_value_in = data;
      end
      @(posedge clk); #1;
      sel_in = 1'b0; write_mask_in = 4'h0;
      obs_q.push_back({aled, kled_tri});
    end
  endtask

  task automatic do_reset;
    sel_in = 1'b0; read_in = 1'b0; write_mask_in = 4'h0; write_value_in = 32'd0;
    address_in = 32'd0; reset = 1'b0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [31:0] rd, e;
    logic [7:0] o, ex;
    do_reset;
    bus_write(AD_PRE, 4'hF, 32'd0);
    bus_write(AD_CTRL, 4'h1, 32'd1);
    exp_q.push_back(model_out(29, 0, 64'd0, 1'b0));
    repeat (30) @(posedge clk);
    #1; obs_q.push_back({aled, kled_tri});
    @(negedge clk);
    address_in = AD_PRE; sel_in = 1'b1; read_in = 1'b1; reset = 1'b0;
    exp_q.push_back(OFF);
    #1; obs_q.push_back({aled, kled_tri});
    for (int i = 0; i < 2; i++) begin
      ex = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== ex) begin
        n_err++; $display("FAIL reset_pads[%0d]: got %b want %b", i, o, ex);
      end
    end
    n_cmp++;
    if (read_value_out !== 32'd0) begin
      n_err++; $display("FAIL reset_rdata: got %h want 00000000", read_value_out);
    end
    sel_in = 1'b0; read_in = 1'b0;
    @(posedge clk); @(negedge clk); reset = 1'b1;
    exp_rd_q.push_back(32'd999); exp_rd_q.push_back(32'd0);
    exp_rd_q.push_back(32'd0);   exp_rd_q.push_back(32'd0);
    for (int i = 0; i < 4; i++) begin
      bus_read((i == 0) ? AD_PRE : (i == 1) ? AD_STAT : (i == 2) ? AD_CTRL : AD_LO, rd);
      e = exp_rd_q.pop_front(); n_cmp++;
      if (rd !== e) begin
        n_err++; $display("FAIL reset_reg[%0d]: got %h want %h", i, rd, e);
      end
    end
  endtask

  task automatic test_scan_basic;
    logic [31:0] rd, e;
    logic [7:0] o, ex;
    int idx;
    do_reset;
    bus_write(AD_PRE, 4'hF, 32'd0);
    bus_write(AD_LO, 4'hF, 32'h0000_000F);
    bus_write(AD_CTRL, 4'h1, 32'd1);
    for (int i = 0; i < 72; i++) exp_q.push_back(model_out(i - 1, 0, {32'd0, 32'h0000_000F}, 1'b0));
    capture(72, -1, AD_CTRL, 4'h0, 32'd0);
    idx = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ex = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== ex) begin
        n_err++; $display("FAIL scan_basic[%0d]: got %b want %b", idx, o, ex);
      end
      idx++;
    end
    exp_rd_q.push_back(model_status(71, 0));
    bus_read(AD_STAT, rd);
    e = exp_rd_q.pop_front(); n_cmp++;
    if (rd !== e) begin
      n_err++; $display("FAIL scan_basic_status: got %h want %h", rd, e);
    end
  endtask

  task automatic test_pwm_half;
    logic [31:0] rd, e;
    logic [7:0] o, ex;
    int idx;
    do_reset;
    bus_write(AD_PRE, 4'hF, 32'd3);
    bus_write(AD_LO, 4'hF, 32'h0080_0000);
    bus_write(AD_CTRL, 4'h1, 32'd1);
    for (int i = 0; i < 274; i++) exp_q.push_back(model_out(i - 1, 3, {32'd0, 32'h0080_0000}, 1'b0));
    capture(274, -1, AD_CTRL, 4'h0, 32'd0);
    idx = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ex = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== ex) begin
        n_err++; $display("FAIL pwm_half[%0d]: got %b want %b", idx, o, ex);
      end
      idx++;
    end
    exp_rd_q.push_back(model_status(273, 3));
    bus_read(AD_STAT, rd);
    e = exp_rd_q.pop_front(); n_cmp++;
    if (rd !== e) begin
      n_err++; $display("FAIL pwm_half_status: got %h want %h", rd, e);
    end
  endtask

  task automatic test_tear_free;
    logic [7:0] o, ex;
    int idx;
    do_reset;
    bus_write(AD_PRE, 4'hF, 32'd0);
    bus_write(AD_CTRL, 4'h1, 32'd1);
    for (int i = 0; i < 140; i++)
      exp_q.push_back(model_out(i - 1, 0, (i - 1 >= 68) ? {32'hFFFF_FFFF, 32'd0} : 64'd0, 1'b0));
    capture(140, 10, AD_HI, 4'hF, 32'hFFFF_FFFF);
    idx = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ex = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== ex) begin
        n_err++; $display("FAIL tear_free[%0d]: got %b want %b", idx, o, ex);
      end
      idx++;
    end
  endtask

  task automatic test_blank;
    logic [7:0] o, ex;
    int idx;
    do_reset;
    bus_write(AD_PRE, 4'hF, 32'd0);
    bus_write(AD_LO, 4'hF, 32'h0000_FFFF);
    bus_write(AD_CTRL, 4'h1, 32'd1);
    for (int i = 0; i < 40; i++)
      exp_q.push_back(model_out(i - 1, 0, {32'd0, 32'h0000_FFFF}, i >= 6));
    capture(40, 5, AD_CTRL, 4'h1, 32'd3);
    idx = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ex = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== ex) begin
        n_err++; $display("FAIL blank[%0d]: got %b want %b", idx, o, ex);
      end
      idx++;
    end
  endtask

  task automatic test_disable;
    logic [31:0] rd, e;
    logic [7:0] o, ex;
    logic [63:0] sh;
    int idx;
    sh = {32'h3C96_A50F, 32'h0F0F_5A5A};
    do_reset;
    bus_write(AD_PRE, 4'hF, 32'd0);
    bus_write(AD_LO, 4'hF, sh[31:0]);
    bus_write(AD_HI, 4'hF, sh[63:32]);
    bus_write(AD_CTRL, 4'h1, 32'd1);
    for (int i = 0; i < 112; i++) exp_q.push_back((i < 109) ? model_out(i - 1, 0, sh, 1'b0) : OFF);
    capture(112, 109, AD_CTRL, 4'h1, 32'd0);
    idx = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ex = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== ex) begin
        n_err++; $display("FAIL disable[%0d]: got %b want %b", idx, o, ex);
      end
      idx++;
    end
    exp_rd_q.push_back(32'h0000_0001);
    bus_read(AD_STAT, rd);
    e = exp_rd_q.pop_front(); n_cmp++;
    if (rd !== e) begin
      n_err++; $display("FAIL disable_status: got %h want %h", rd, e);
    end
    bus_write(AD_CTRL, 4'h1, 32'd1);
    for (int i = 0; i < 20; i++) exp_q.push_back(model_out(i - 1, 0, sh, 1'b0));
    capture(20, -1, AD_CTRL, 4'h0, 32'd0);
    idx = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ex = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== ex) begin
        n_err++; $display("FAIL reenable[%0d]: got %b want %b", idx, o, ex);
      end
      idx++;
    end
    exp_rd_q.push_back(model_status(19, 0) | 32'h0000_0001);
    bus_read(AD_STAT, rd);
    e = exp_rd_q.pop_front(); n_cmp++;
    if (rd !== e) begin
      n_err++; $display("FAIL reenable_status: got %h want %h", rd, e);
    end
  endtask

  task automatic test_prescale_lower;
    logic [7:0] o, ex;
    int idx;
    do_reset;
    bus_write(AD_LO, 4'hF, 32'h0000_0002);
    bus_write(AD_CTRL, 4'h1, 32'd1);
    for (int i = 0; i < 121; i++) exp_q.push_back((i < 102) ? OFF : model_out(i - 98, 3, 64'h2, 1'b0));
    capture(121, 100, AD_PRE, 4'h3, 32'd3);
    idx = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ex = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== ex) begin
        n_err++; $display("FAIL prescale_lower[%0d]: got %b want %b", idx, o, ex);
      end
      idx++;
    end
  endtask

  task automatic test_regs;
    logic [31:0] rd, e;
    logic [31:0] addrs[9];
    do_reset;
    bus_write(AD_LO, 4'b0010, 32'h0000_AB00);
    exp_rd_q.push_back(32'h0000_AB00);
    bus_read(AD_LO, rd);
    e = exp_rd_q.pop_front(); n_cmp++;
    if (rd !== e) begin
      n_err++; $display("FAIL masked_lane1: got %h want %h", rd, e);
    end
    bus_write(AD_LO, 4'b0100, 32'hFFFF_FFFF);
    bus_write(AD_PRE, 4'hF, 32'hFFFF_FFFF);
    bus_write(AD_PRE, 4'b0001, 32'h5555_5512);
    bus_write(AD_R5, 4'hF, 32'hFFFF_FFFF);
    bus_write(AD_STAT, 4'hF, 32'hFFFF_FFFF);
    address_in = AD_HI; write_mask_in = 4'hF; write_value_in = 32'hDEAD_BEEF; sel_in = 1'b0;
    @(posedge clk); #1; write_mask_in = 4'h0;
    addrs = '{AD_LO, 32'h0004_0028, AD_PRE, AD_R5, AD_R7, AD_STAT, AD_CTRL, AD_HI, AD_LO};
    exp_rd_q.push_back(32'h00FF_AB00); exp_rd_q.push_back(32'h00FF_AB00);
    exp_rd_q.push_back(32'h0000_FF12); exp_rd_q.push_back(32'd0);
    exp_rd_q.push_back(32'd0);         exp_rd_q.push_back(32'd0);
    exp_rd_q.push_back(32'd0);         exp_rd_q.push_back(32'd0);
    exp_rd_q.push_back(32'h00FF_AB00);
    for (int i = 0; i < 9; i++) begin
      bus_read(addrs[i], rd);
      e = exp_rd_q.pop_front(); n_cmp++;
      if (rd !== e) begin
        n_err++; $display("FAIL reg_read[%0d] @%h: got %h want %h", i, addrs[i], rd, e);
      end
    end
    @(negedge clk);
    address_in = AD_LO; sel_in = 1'b1; read_in = 1'b1; #1;
    n_cmp++;
    if (ready_out !== 1'b1) begin
      n_err++; $display("FAIL ready_sel1: got %b want 1", ready_out);
    end
    sel_in = 1'b0; #1;
    n_cmp++;
    if (read_value_out !== 32'd0 || ready_out !== 1'b0) begin
      n_err++; $display("FAIL sel0_gate: got rdata %h ready %b want 00000000 0", read_value_out, ready_out);
    end
    read_in = 1'b0;
  endtask

  task automatic test_frame_wrap;
    logic [31:0] rd, e;
    do_reset;
    bus_write(AD_PRE, 4'hF, 32'd0);
    bus_write(AD_CTRL, 4'h1, 32'd1);
    repeat (17408) @(posedge clk);
    exp_rd_q.push_back(model_status(17407, 0));
    bus_read(AD_STAT, rd);
    e = exp_rd_q.pop_front(); n_cmp++;
    if (rd !== e) begin
      n_err++; $display("FAIL frame_255: got %h want %h", rd, e);
    end
    @(posedge clk);
    exp_rd_q.push_back(model_status(17408, 0));
    bus_read(AD_STAT, rd);
    e = exp_rd_q.pop_front(); n_cmp++;
    if (rd !== e) begin
      n_err++; $display("FAIL frame_wrap: got %h want %h", rd, e);
    end
  endtask

  initial begin
    reset = 1'b0; sel_in = 1'b0; read_in = 1'b0; write_mask_in = 4'h0;
    write_value_in = 32'd0; address_in = 32'd0;
    test_reset;
    test_scan_basic;
    test_pwm_half;
    test_tear_free;
    test_blank;
    test_disable;
    test_prescale_lower;
    test_regs;
    test_frame_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached after %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led4x4_scan_ctrl.md
Name: led4x4_scan_ctrl

Overview:
Memory-mapped scan controller for the 4x4 Doppler LED matrix. It replaces static 16-bit LED writes with per-LED 4-bit PWM brightness, row sequencing and blanking. It sits on the common memory bus as a slave at 0x0004_00xx and drives the anode lines and cathode output-enables directly. Cathode pads stay in SB_IO instances outside this block.

Parameters:
RESET_PRESCALE, 16'd999, PRESCALE register value after reset (PWM tick = PRESCALE+1 clocks).

Ports:
clk  input  1  system clock (pll_clk)
reset  input  1  asynchronous, active-low reset (0 = in reset)
address_in  input  32  bus address; only [4:2] decoded
sel_in  input  1  slave select from top-level decode
read_in  input  1  bus read strobe (reads have no side effects)
read_value_out  output  32  read data; 0 when sel_in=0
write_mask_in  input  4  byte write enables
write_value_in  input  32  write data
ready_out  output  1  equals sel_in (single-cycle slave)
aled  output  4  anode row drive, one-hot, active high
kled_tri  output  4  cathode OE; 1 = driven high (LED off), 0 = released (LED on if its row is active)

Behaviour:
- Register map (word offset = address_in[4:2]):
  - 0 CTRL: [0] enable, [1] blank. Reset 0.
  - 1 PRESCALE: [15:0]. Reset RESET_PRESCALE.
  - 2 BRIGHT_LO: nibble n = LED n (n=0..7).
  - 3 BRIGHT_HI: nibble n = LED 8+n. Both reset 0.
  - 4 STATUS (read-only): [7:0] frame_cnt, [9:8] row, [10] busy (state != IDLE).
  - Offsets 5-7 read 0; writes are ignored.
- Writes occur when sel_in and the relevant write_mask_in bit are set; byte lanes are independent. Write data takes effect the cycle after.
- read_value_out is combinational from the register or live counters, gated by sel_in. ready_out = sel_in.
- LED index = row*4 + col; col k maps to kled_tri[k], row r maps to aled[r].
- Tick generator: 16-bit counter pc.
  - tick = (pc >= PRESCALE); on tick, pc <= 0, else pc+1.
  - If PRESCALE is lowered below pc, a tick fires on the next cycle.
  - pc is held at 0 in IDLE.
- FSM states:
  - IDLE: aled=0, kled_tri=4'hF. When enable=1, go to BLANK with row=0, phase=0, and latch BRIGHT_LO/HI into shadow registers.
  - BLANK: aled=0, kled_tri=4'hF for 1 tick. On tick go to ACTIVE, phase=0.
  - ACTIVE: aled=one-hot(row). kled_tri[c] = ~(shadow[row*4+c] > phase) | blank. Lasts 16 ticks, with phase 0..15 advancing on each tick.
    - On the tick at phase 15: row = row+1 (mod 4) and go to BLANK.
    - When leaving row 3: frame_cnt += 1 (wraps 255 -> 0) and re-latch the shadow registers.
- Shadow latch happens only at frame start, so brightness writes never tear within a frame.
- Frame length = 4 x (1+16) = 68 ticks = 68 x (PRESCALE+1) clocks.
- Brightness 0 = always off; 15 = on 15 of 16 phases.
- Writing enable=0 in any state: next cycle IDLE, outputs off, row=0, phase=0. frame_cnt is retained.
- blank=1 forces kled_tri=4'hF in ACTIVE without stopping the sequencing.
- aled and kled_tri are registered: they change one cycle after the state/phase update and are never both active during BLANK.
- Asynchronous reset (reset=0): all registers take reset values immediately, FSM=IDLE, aled=0, kled_tri=4'hF, read_value_out=0. Reset mid-frame behaves identically.

Test Plan:
1. Reset: hold reset=0 mid-frame -> aled=0, kled_tri=F, PRESCALE reads 999, STATUS reads 0.
2. PRESCALE=0, BRIGHT_LO=0x0000_000F, enable=1 -> row 0: aled=0001 for 16 clocks after 1 blank clock; kled_tri[0]=0 for phases 0..14 and 1 at phase 15. All other LEDs stay off. frame_cnt=1 after 68 clocks.
3. PRESCALE=3, LED5 brightness 8 -> row 1 active for 64 clocks; kled_tri[1]=0 for the first 32 clocks, then 1.
4. Write BRIGHT_HI=0xFFFF_FFFF mid-frame -> rows 2/3 stay off until the next frame start, then fully lit 15/16.
5. enable=0 written during ACTIVE row 2 -> next cycle aled=0, busy=0, frame_cnt unchanged. Re-enable restarts at row 0 with a blank.
6. Byte-masked write 0x0000_AB00 with mask 0010 to BRIGHT_LO -> reads 0x0000_AB00. sel_in=0 -> read_value_out=0, ready_out=0. 256 frames with PRESCALE=0 -> frame_cnt wraps to 0.
